hdmi_video_timing: RTL and testbench
====================================

# hdmi_video_timing

Pixel-clock video timing generator and pixel alignment pipeline for the HDMI/VGA output path. It sits directly upstream of the DVI transmitter and the 4-bit VGA pins. It produces stage-0 pixel coordinates for the lab's pixel-generating logic. It then re-aligns the returned colour with delayed hsync/vsync/data-enable, so the transmitter receives a real `de` instead of a constant 1.

## Interface
Parameters:
- `H_ACTIVE` 640: visible pixels per line
- `H_FRONT` 16: horizontal front porch, pixels
- `H_SYNC` 96: hsync width, pixels
- `H_BACK` 48: horizontal back porch, pixels
- `V_ACTIVE` 480: visible lines
- `V_FRONT` 10: vertical front porch, lines
- `V_SYNC` 2: vsync width, lines
- `V_BACK` 33: vertical back porch, lines
- `HS_POL` 0: hsync active level
- `VS_POL` 0: vsync active level
- `PIX_LAT` 1: colour latency of user logic, cycles after `x`/`y` (legal range 0..4)
- `W_X` 10, `W_Y` 10: coordinate widths; each must hold its respective TOTAL-1
- `W_COLOR` 8: bits per colour channel

Ports:
- `clk` in 1: pixel clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `x` out W_X: stage-0 horizontal counter
- `y` out W_Y: stage-0 vertical counter
- `req` out 1: stage-0 active area, (x < H_ACTIVE) && (y < V_ACTIVE)
- `frame_start` out 1: one-cycle pulse when x==0 && y==0
- `line_start` out 1: one-cycle pulse when x==0
- `rgb_in` in 3*W_COLOR: {r,g,b} for the coordinate presented PIX_LAT cycles earlier
- `hsync`, `vsync`, `de` out 1 each: aligned output timing
- `red`, `green`, `blue` out W_COLOR each: aligned colour

## Operation
- H_TOTAL = sum of the four H parameters (800 by default). V_TOTAL = sum of the four V parameters (525 by default).
- `x` counts 0..H_TOTAL-1 and wraps to 0.
- `y` increments only in the cycle where `x` wraps; `y` wraps from V_TOTAL-1 to 0 under the same condition.
- `x`, `y`, `req`, `frame_start` and `line_start` are registered. They all describe the same pixel in the same cycle.
- Stage-0 hsync is active iff H_ACTIVE+H_FRONT ≤ x < H_ACTIVE+H_FRONT+H_SYNC.
- Stage-0 vsync is active iff V_ACTIVE+V_FRONT ≤ y < V_ACTIVE+V_FRONT+V_SYNC. vsync changes together with x==0 (line-aligned).
- Stage-0 `de` = `req`.
- Delay line: stage-0 hsync/vsync/de pass through a shift register of PIX_LAT stages.
- `rgb_in` is sampled in the same cycle the delayed `de` emerges.
- One final output register drives `hsync`, `vsync`, `de`, `red`, `green`, `blue`.
- Colour is forced to 0 whenever the aligned `de` is 0.
- Output levels: active sync = HS_POL/VS_POL; inactive = the inverse.

## Timing
- Latency from `x`/`y` to the matching `hsync`/`vsync`/`de`/colour outputs: PIX_LAT+1 cycles.
- Reset, asserted at an edge: state at that edge is
  - `x`=0, `y`=0, `req`=0, `frame_start`=0, `line_start`=0
  - all delay stages cleared to inactive (de 0, syncs at their inactive level)
  - `hsync`=~HS_POL, `vsync`=~VS_POL, `de`=0, colour 0
- First cycle after `rst` deasserts: `x`=0, `y`=0, `req`=1, `frame_start`=1, `line_start`=1.
- Output `de` first rises PIX_LAT+1 cycles after `rst` deasserts.
- Reset mid-frame takes effect at the next edge with no partial-line completion. Outputs reach inactive levels the same edge; no stale pipeline data emerges afterward.
- Wrap-around: in the cycle with x==H_TOTAL-1 and y==V_TOTAL-1, the next edge gives x=0, y=0 and `frame_start`=1.
- No gaps between frames and no skipped counts.
- `rgb_in` is ignored while aligned de=0. X/Z on `rgb_in` there must not reach the outputs.

## Test plan
- Reset values: hold `rst` 5 cycles with default params. Expect:
  - `hsync`=1, `vsync`=1, `de`=0, colour 0, `x`=`y`=0, `req`=0
  - on release: `frame_start`=1 in the first cycle, then 0 for the next 419999 cycles, then 1 again (period 420000)
- Small geometry: H 4/1/2/1, V 3/1/1/1, PIX_LAT 1.
  - H_TOTAL=8, V_TOTAL=6; per line `x` reads 0..7.
  - Stage-0 hsync is active at x=5,6; output `hsync` is low 2 cycles later.
  - vsync is low for the 8 cycles of y=4; a frame is 48 cycles.
- Alignment: drive `rgb_in` = {x,y,8'hA5} registered PIX_LAT times, for PIX_LAT=0,1,3.
  - Every cycle with `de`=1 must show `red` = the x that was presented PIX_LAT+1 cycles earlier.
  - `de`=1 must occur exactly 12 cycles per 48-cycle frame in the small geometry.
- Blanking: drive `rgb_in`=24'hFFFFFF constantly → colour is 0 exactly when `de`=0.
- Reset mid-frame: assert `rst` at x=3, y=2 for 1 cycle.
  - Next edge: all outputs are at reset values.
  - After release: the sequence restarts from x=0, y=0, with no `de` pulse before PIX_LAT+1 cycles.
- Polarity: HS_POL=1, VS_POL=1 → `hsync`/`vsync` idle at 0 (including during reset) and pulse to 1 at the same positions as in the small-geometry scenario.

Source files
------------

// File: rtl/hdmi_video_timing_if.sv
// rtl/hdmi_video_timing_if.sv - pixel request and aligned video output bundle
// master (timing generator): drives x, y, req, frame_start, line_start,
//   hsync, vsync, de, red, green, blue; receives rgb_in from pixel logic.
// slave (pixel logic / transmitter side): the mirror image.
interface hdmi_video_timing_if #(
    parameter int W_X     = 10,
    parameter int W_Y     = 10,
    parameter int W_COLOR = 8
);
    logic [W_X-1:0]       x;
    logic [W_Y-1:0]       y;
    logic                 req;
    logic                 frame_start;
    logic                 line_start;
    logic [3*W_COLOR-1:0] rgb_in;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [W_COLOR-1:0]   red;
    logic [W_COLOR-1:0]   green;
    logic [W_COLOR-1:0]   blue;

    modport master (
        output x, y, req, frame_start, line_start,
        output hsync, vsync, de, red, green, blue,
        input  rgb_in
    );

    modport slave (
        input  x, y, req, frame_start, line_start,
        input  hsync, vsync, de, red, green, blue,
        output rgb_in
    );
endinterface

// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - video timing generator with pixel alignment pipeline
// clk: pixel clock; rst: synchronous active-high reset.
// vid (master): stage-0 x/y/req/frame_start/line_start out, rgb_in back from
//   pixel logic PIX_LAT cycles later, aligned hsync/vsync/de/red/green/blue out.
module hdmi_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 1,
    parameter int W_X      = 10,
    parameter int W_Y      = 10,
    parameter int W_COLOR  = 8
) (
    input  logic                clk,
    input  logic                rst,
    hdmi_video_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [W_X-1:0] X_LAST = W_X'(H_TOTAL - 1);
    localparam logic [W_X-1:0] X_ACT  = W_X'(H_ACTIVE);
    localparam logic [W_X-1:0] HS_BEG = W_X'(H_ACTIVE + H_FRONT);
    localparam logic [W_X-1:0] HS_END = W_X'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [W_Y-1:0] Y_LAST = W_Y'(V_TOTAL - 1);
    localparam logic [W_Y-1:0] Y_ACT  = W_Y'(V_ACTIVE);
    localparam logic [W_Y-1:0] VS_BEG = W_Y'(V_ACTIVE + V_FRONT);
    localparam logic [W_Y-1:0] VS_END = W_Y'(V_ACTIVE + V_FRONT + V_SYNC);

    // Stage 0: coordinate counters and their per-pixel flags.
    logic           started_q, started_d;
    logic [W_X-1:0] x_q, x_d;
    logic [W_Y-1:0] y_q, y_d;
    logic           req_q, req_d;
    logic           fs_q, fs_d;
    logic           ls_q, ls_d;

    // The first edge out of reset presents pixel (0,0) rather than (1,0),
    // so the counters hold at zero until started_q is set.
    always_comb begin
        started_d = 1'b1;
        x_d       = '0;
        y_d       = '0;
        if (started_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
                y_d = y_q;
            end
        end
        req_d = (x_d < X_ACT) && (y_d < Y_ACT);
        ls_d  = (x_d == '0);
        fs_d  = ls_d && (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            req_q     <= 1'b0;
            fs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            started_q <= started_d;
            x_q       <= x_d;
            y_q       <= y_d;
            req_q     <= req_d;
            fs_q      <= fs_d;
            ls_q      <= ls_d;
        end
    end

    // Stage-0 timing as active-high flags {hsync, vsync, de}; polarity is
    // applied only at the output so a cleared delay stage means inactive.
    logic [2:0] s0;
    assign s0 = {(x_q >= HS_BEG) && (x_q < HS_END),
                 (y_q >= VS_BEG) && (y_q < VS_END),
                 req_q};

    logic [2:0] dly;

    if (PIX_LAT == 0) begin : g_no_dly
        assign dly = s0;
    end else begin : g_dly
        logic [2:0] sr_q [PIX_LAT];
        logic [2:0] sr_d [PIX_LAT];

        always_comb begin
            sr_d[0] = s0;
            for (int i = 1; i < PIX_LAT; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                sr_q[i] <= rst ? 3'b000 : sr_d[i];
            end
        end

        assign dly = sr_q[PIX_LAT-1];
    end

    // Output register. Colour is only taken from rgb_in while the aligned de
    // is high, so anything on rgb_in during blanking never propagates.
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [W_COLOR-1:0] red_q, red_d;
    logic [W_COLOR-1:0] green_q, green_d;
    logic [W_COLOR-1:0] blue_q, blue_d;

    always_comb begin
        hsync_d = dly[2] ? HS_POL : ~HS_POL;
        vsync_d = dly[1] ? VS_POL : ~VS_POL;
        de_d    = dly[0];
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (dly[0]) begin
            red_d   = vid.rgb_in[3*W_COLOR-1 -: W_COLOR];
            green_d = vid.rgb_in[2*W_COLOR-1 -: W_COLOR];
            blue_d  = vid.rgb_in[W_COLOR-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.req         = req_q;
    assign vid.frame_start = fs_q;
    assign vid.line_start  = ls_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.red         = red_q;
    assign vid.green       = green_q;
    assign vid.blue        = blue_q;
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb/tb_hdmi_video_timing.sv - scoreboard bench for hdmi_video_timing
module tb_hdmi_video_timing;
    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic rst_d = 1'b1;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    hdmi_video_timing_if vd ();
    hdmi_video_timing_if vs0 ();
    hdmi_video_timing_if vs1 ();
    hdmi_video_timing_if vs3 ();
    hdmi_video_timing_if vsb ();
    hdmi_video_timing_if vsp ();

    hdmi_video_timing u_def (.clk(clk), .rst(rst_d), .vid(vd));

    hdmi_video_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                        .PIX_LAT(0)) u_s0 (.clk(clk), .rst(rst_s), .vid(vs0));
    hdmi_video_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                        .PIX_LAT(1)) u_s1 (.clk(clk), .rst(rst_s), .vid(vs1));
    hdmi_video_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                        .PIX_LAT(3)) u_s3 (.clk(clk), .rst(rst_s), .vid(vs3));
    hdmi_video_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                        .PIX_LAT(1)) u_sb (.clk(clk), .rst(rst_s), .vid(vsb));
    hdmi_video_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                        .HS_POL(1'b1), .VS_POL(1'b1),
                        .PIX_LAT(1)) u_sp (.clk(clk), .rst(rst_s), .vid(vsp));

    // Small-geometry instances: index -> output latency, polarity, blank-test.
    localparam int NI = 5;
    localparam int LAT [NI] = '{1, 2, 4, 2, 2};
    localparam bit POL [NI] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit BLK [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [26:0] obs [NI];
    assign obs[0] = {vs0.hsync, vs0.vsync, vs0.de, vs0.red, vs0.green, vs0.blue};
    assign obs[1] = {vs1.hsync, vs1.vsync, vs1.de, vs1.red, vs1.green, vs1.blue};
    assign obs[2] = {vs3.hsync, vs3.vsync, vs3.de, vs3.red, vs3.green, vs3.blue};
    assign obs[3] = {vsb.hsync, vsb.vsync, vsb.de, vsb.red, vsb.green, vsb.blue};
    assign obs[4] = {vsp.hsync, vsp.vsync, vsp.de, vsp.red, vsp.green, vsp.blue};

    logic [26:0] sbq [NI][$];
    logic [23:0] hist [4] = '{default: 24'h0};

    // Reference model of the small-geometry stage-0 counters.
    int m_run = 0;
    int mx = 0;
    int my = 0;
    int m_req = 0;
    int m_fs = 0;
    int m_ls = 0;

    function automatic logic [26:0] exp_out(input int i, input int run, input int px, input int py);
        logic hs_a, vs_a, d;
        logic [23:0] c;
        hs_a = (run != 0) && px >= 5 && px < 7;
        vs_a = (run != 0) && py == 4;
        d    = (run != 0) && px < 4 && py < 3;
        c    = BLK[i] ? 24'hFFFFFF : {8'(px), 8'(py), 8'hA5};
        if (!d) c = 24'h0;
        return {hs_a ? POL[i] : ~POL[i], vs_a ? POL[i] : ~POL[i], d, c};
    endfunction

    always begin
        logic [26:0] e;
        @(posedge clk);
        #2;
        if (rst_s) begin
            m_run = 0; mx = 0; my = 0;
        end else if (m_run == 0) begin
            m_run = 1; mx = 0; my = 0;
        end else if (mx == 7) begin
            mx = 0;
            my = (my == 5) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        m_req = (m_run != 0 && mx < 4 && my < 3) ? 1 : 0;
        m_ls  = (m_run != 0 && mx == 0) ? 1 : 0;
        m_fs  = (m_ls != 0 && my == 0) ? 1 : 0;

        chk("s1_x", vs1.x, mx);
        chk("s1_y", vs1.y, my);
        chk("s1_req", vs1.req, m_req);
        chk("s1_frame_start", vs1.frame_start, m_fs);
        chk("s1_line_start", vs1.line_start, m_ls);

        for (int i = 0; i < NI; i++) begin
            if (rst_s) begin
                sbq[i].delete();
                for (int k = 0; k < LAT[i]; k++) sbq[i].push_back(exp_out(i, 0, 0, 0));
            end
            sbq[i].push_back(exp_out(i, m_run, mx, my));
            if (sbq[i].size() > LAT[i]) begin
                e = sbq[i].pop_front();
                chk($sformatf("sb%0d_out", i), obs[i], e);
            end
        end

        // User pixel logic: colour {x,y,A5} returned PIX_LAT cycles later.
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {vs1.x[7:0], vs1.y[7:0], 8'hA5};
        vs0.rgb_in = hist[0];
        vs1.rgb_in = hist[1];
        vs3.rgb_in = hist[3];
        vsp.rgb_in = hist[1];
    end

    task automatic def_seq();
        int n_fs = 0;
        int n_ls = 0;
        repeat (5) @(posedge clk);
        #3;
        chk("def_rst_hsync", vd.hsync, 1);
        chk("def_rst_vsync", vd.vsync, 1);
        chk("def_rst_de", vd.de, 0);
        chk("def_rst_rgb", {vd.red, vd.green, vd.blue}, 0);
        chk("def_rst_x", vd.x, 0);
        chk("def_rst_y", vd.y, 0);
        chk("def_rst_req", vd.req, 0);
        chk("def_rst_fs", vd.frame_start, 0);
        rst_d = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #3;
            if (k == 1) begin
                chk("def_first_fs", vd.frame_start, 1);
                chk("def_first_ls", vd.line_start, 1);
                chk("def_first_req", vd.req, 1);
                chk("def_first_x", vd.x, 0);
                chk("def_first_y", vd.y, 0);
            end else begin
                n_fs += int'(vd.frame_start);
            end
            n_ls += int'(vd.line_start);
            if (k == 2)    chk("def_de_before", vd.de, 0);
            if (k == 3)    chk("def_de_rise", vd.de, 1);
            if (k == 3)    chk("def_red_first", vd.red, 8'h12);
            if (k == 642)  chk("def_de_last", vd.de, 1);
            if (k == 643)  chk("def_de_fall", vd.de, 0);
            if (k == 643)  chk("def_rgb_blank", {vd.red, vd.green, vd.blue}, 0);
            if (k == 658)  chk("def_hs_pre", vd.hsync, 1);
            if (k == 659)  chk("def_hs_start", vd.hsync, 0);
            if (k == 754)  chk("def_hs_end", vd.hsync, 0);
            if (k == 755)  chk("def_hs_post", vd.hsync, 1);
            if (k == 801)  chk("def_y_line1", vd.y, 1);
            if (k == 2000) chk("def_vsync_idle", vd.vsync, 1);
        end
        chk("def_fs_quiet", n_fs, 0);
        chk("def_ls_count", n_ls, 3);
    endtask

    task automatic small_seq();
        int n0 = 0;
        int n1 = 0;
        int n3 = 0;
        int found = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("pol_rst_hsync", vsp.hsync, 0);
        chk("pol_rst_vsync", vsp.vsync, 0);
        rst_s = 1'b0;
        repeat (10) @(posedge clk);
        for (int k = 0; k < 48; k++) begin
            @(posedge clk);
            #3;
            n0 += int'(vs0.de);
            n1 += int'(vs1.de);
            n3 += int'(vs3.de);
        end
        chk("s0_de_per_frame", n0, 12);
        chk("s1_de_per_frame", n1, 12);
        chk("s3_de_per_frame", n3, 12);
        repeat (60) @(posedge clk);
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(posedge clk);
            #3;
            if (mx == 3 && my == 2) found = 1;
        end
        chk("midframe_found", found, 1);
        rst_s = 1'b1;
        @(posedge clk);
        #3;
        rst_s = 1'b0;
        chk("mid_rst_de", vs3.de, 0);
        chk("mid_rst_hsync", vs1.hsync, 1);
        chk("mid_rst_pol_hsync", vsp.hsync, 0);
        chk("mid_rst_red", vs3.red, 0);
        chk("mid_rst_x", vs1.x, 0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #3;
            chk($sformatf("mid_restart_s3_de_%0d", k), vs3.de, (k == 5) ? 1 : 0);
            chk($sformatf("mid_restart_s1_de_%0d", k), vs1.de, (k >= 3) ? 1 : 0);
        end
        repeat (130) @(posedge clk);
    endtask

    initial begin
        vd.rgb_in  = 24'h123456;
        vsb.rgb_in = 24'hFFFFFF;
        vs0.rgb_in = 24'h0;
        vs1.rgb_in = 24'h0;
        vs3.rgb_in = 24'h0;
        vsp.rgb_in = 24'h0;
        fork
            def_seq();
            small_seq();
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
